hazard_scoreboard_unit: RTL

//   Parametrised successor to the single-cycle load-use detector. Tracks up to
//   MAX_PENDING long-latency results (loads, mul/div) with per-entry countdowns.

---
 rtl/hazard_scoreboard_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard_unit.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_unit
//   Tracks outstanding long-latency results (loads, mul/div) in a small table
//   of {valid, rd, cnt} entries. Each entry counts down toward the cycle where
//   its result becomes forwardable. The unit stalls ID and bubbles ID/EX when
//   the ID instruction reads (RAW) or writes (WAW) a register that is still
//   pending. It also stalls when the table is full. With a latency of 1 the
//   unit behaves like a classic lw->use detector.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   issue_valid_ex   long-latency op present in EX this cycle
//   issue_rd_ex      destination register of that op
//   issue_lat_ex     cycles until its result is forwardable (0 = no hazard)
//   rs1_addr_id/rs2_addr_id, rs1_used_id/rs2_used_id   ID source operands
//   rd_addr_id, rd_write_id                            ID destination
//   flush_i          ID instruction squashed by a branch redirect
//   stall_pipeline   combinational: hold PC and IF/ID
//   flush_id_ex      combinational: bubble into ID/EX (same as stall_pipeline)
//   pending_mask     registered: bit r set while r is held in the table
//   sb_full          registered: every entry valid
//   overflow_err     sticky: an issue needing an entry arrived while full
//   stall_cycles     saturating count of stalled cycles
// ----------------------------------------------------------------------------
module hazard_scoreboard_unit #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned LAT_W       = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid_ex,
    input  logic [ADDR_W-1:0]        issue_rd_ex,
    input  logic [LAT_W-1:0]         issue_lat_ex,
    input  logic [ADDR_W-1:0]        rs1_addr_id,
    input  logic [ADDR_W-1:0]        rs2_addr_id,
    input  logic                     rs1_used_id,
    input  logic                     rs2_used_id,
    input  logic [ADDR_W-1:0]        rd_addr_id,
    input  logic                     rd_write_id,
    input  logic                     flush_i,
    output logic                     stall_pipeline,
    output logic                     flush_id_ex,
    output logic [(2**ADDR_W)-1:0]   pending_mask,
    output logic                     sb_full,
    output logic                     overflow_err,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;
    localparam int unsigned IDX_W    = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

    // Scoreboard table
    logic [MAX_PENDING-1:0] ent_valid;
    logic [ADDR_W-1:0]      ent_rd  [MAX_PENDING];
    logic [LAT_W-1:0]       ent_cnt [MAX_PENDING];

    logic [MAX_PENDING-1:0] valid_nxt;
    logic [ADDR_W-1:0]      rd_nxt  [MAX_PENDING];
    logic [LAT_W-1:0]       cnt_nxt [MAX_PENDING];
    logic [NUM_REGS-1:0]    mask_nxt;

    logic             issue_acc;
    logic             needs_entry;
    logic             alloc;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             rd_hit;
    logic             raw;
    logic             waw;

    // Issue qualification: x0 and zero-latency ops never create a hazard
    always_comb begin
        issue_acc   = issue_valid_ex && (issue_rd_ex != '0) && (issue_lat_ex != '0);
        needs_entry = issue_acc && (issue_lat_ex > LAT_W'(1));
    end

    // Lowest-index entry that is free now; slots retiring this edge are not yet free
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_PENDING - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc = needs_entry && !sb_full && free_found;

    // Operand match against the op in EX and every live entry (cnt=1 still matches)
    always_comb begin
        rs1_hit = issue_acc && (rs1_addr_id == issue_rd_ex);
        rs2_hit = issue_acc && (rs2_addr_id == issue_rd_ex);
        rd_hit  = issue_acc && (rd_addr_id  == issue_rd_ex);
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (ent_valid[i]) begin
                if (ent_rd[i] == rs1_addr_id) rs1_hit = 1'b1;
                if (ent_rd[i] == rs2_addr_id) rs2_hit = 1'b1;
                if (ent_rd[i] == rd_addr_id)  rd_hit  = 1'b1;
            end
        end
        if (rs1_addr_id == '0) rs1_hit = 1'b0;
        if (rs2_addr_id == '0) rs2_hit = 1'b0;
        if (rd_addr_id  == '0) rd_hit  = 1'b0;
    end

    // Stall decision; a squashed ID instruction never stalls
    always_comb begin
        raw            = (rs1_used_id && rs1_hit) || (rs2_used_id && rs2_hit);
        waw            = rd_write_id && rd_hit;
        stall_pipeline = !flush_i && (raw || waw || sb_full);
        flush_id_ex    = stall_pipeline;
    end

    // Next table: count down live entries, then place a new issue in the free slot
    always_comb begin
        valid_nxt = ent_valid;
        for (int i = 0; i < MAX_PENDING; i++) begin
            rd_nxt[i]  = ent_rd[i];
            cnt_nxt[i] = ent_cnt[i];
            if (ent_valid[i]) begin
                cnt_nxt[i] = ent_cnt[i] - LAT_W'(1);
                if (ent_cnt[i] <= LAT_W'(1)) begin
                    valid_nxt[i] = 1'b0;
                end
            end
            if (alloc && (IDX_W'(i) == free_idx)) begin
                valid_nxt[i] = 1'b1;
                rd_nxt[i]    = issue_rd_ex;
                cnt_nxt[i]   = issue_lat_ex - LAT_W'(1);
            end
        end
    end

    // Pending mask follows the table contents after this edge; x0 never pends
    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (valid_nxt[i]) begin
                mask_nxt[rd_nxt[i]] = 1'b1;
            end
        end
        mask_nxt[0] = 1'b0;
    end

    // Table and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid    <= '0;
            for (int i = 0; i < MAX_PENDING; i++) begin
                ent_rd[i]  <= '0;
                ent_cnt[i] <= '0;
            end
            pending_mask <= '0;
            sb_full      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            ent_valid    <= valid_nxt;
            for (int i = 0; i < MAX_PENDING; i++) begin
                ent_rd[i]  <= rd_nxt[i];
                ent_cnt[i] <= cnt_nxt[i];
            end
            pending_mask <= mask_nxt;
            sb_full      <= &valid_nxt;
            if (needs_entry && sb_full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Saturating stall performance counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall_pipeline && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
